ring_shift_ctrl: RTL

Button-driven sequencer for the 9-bit one-hot ring shift register. It debounces two raw push-buttons and arbitrates between them. It issues single-cycle rotate-left, rotate-right and home strobes to the ring register, with auto-repeat while a button is held. It also tracks the hot-bit index for display logic, so the ring register is clocked from clk plus an enable instead of a gated button clock.

---
 rtl/ring_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 41 ++++
 rtl/ring_shift_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and constants for the 9-bit one-hot ring shift sequencer.
// Position helpers keep the wrap arithmetic in one place.
package ring_pkg;

    localparam int          RING_LEN  = 9;
    localparam logic [3:0]  HOME_POS  = 4'd8;
    localparam logic [8:0]  RING_HOME = 9'b100000000;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_L,
        RPT_L,
        HOLD_R,
        RPT_R,
        BOTH,
        LOCK
    } ring_state_t;

    function automatic logic [3:0] pos_left(input logic [3:0] p);
        return (p == 4'(RING_LEN - 1)) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic [3:0] pos_right(input logic [3:0] p);
        return (p == 4'd0) ? 4'(RING_LEN - 1) : p - 4'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level
// only follows the synchronized input after DEB_CYCLES consecutive disagreements.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic _rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            sync_reg  <= 2'b00;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            // Any cycle where the input agrees with the accepted level restarts the count.
            if (sync_reg[1] != level_reg) begin
                if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    level_reg <= sync_reg[1];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/ring_shift_ctrl.sv
// Button sequencer for the one-hot ring: debounces two buttons, arbitrates,
// and issues single-cycle shift/home enables with auto-repeat and a hot-bit index.
module ring_shift_ctrl
    import ring_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 20,
    parameter int CLR_CYCLES    = 100
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       btn1,
    input  logic       btn2,
    output logic       shift_l,
    output logic       shift_r,
    output logic       home,
    output logic [3:0] pos
);

    localparam int TMAX = max3(HOLD_CYCLES, REPEAT_CYCLES, CLR_CYCLES);
    localparam int TW   = $clog2(TMAX);

    logic [1:0] raw_vec;
    logic [1:0] db;

    assign raw_vec = {btn2, btn1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                ._rst (_rst),
                .raw  (raw_vec[gi]),
                .level(db[gi])
            );
        end
    endgenerate

    ring_state_t   state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next, timer_inc;
    logic          shift_l_reg, shift_l_next;
    logic          shift_r_reg, shift_r_next;
    logic          home_reg, home_next;
    logic [3:0]    pos_reg, pos_next;

    assign timer_inc = (&timer_reg) ? timer_reg : timer_reg + 1'b1;

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_inc;
        shift_l_next = 1'b0;
        shift_r_next = 1'b0;
        home_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                timer_next = '0;
                case (db)
                    2'b01: begin
                        shift_l_next = 1'b1;
                        state_next   = HOLD_L;
                    end
                    2'b10: begin
                        shift_r_next = 1'b1;
                        state_next   = HOLD_R;
                    end
                    2'b11:   state_next = BOTH;
                    default: state_next = IDLE;
                endcase
            end

            HOLD_L, RPT_L: begin
                if (db == 2'b11) begin
                    state_next = BOTH;
                    timer_next = '0;
                end else if (db != 2'b01) begin
                    // Release or opposite button: back to IDLE, serviced from there.
                    state_next = IDLE;
                    timer_next = '0;
                end else if ((state_reg == HOLD_L && timer_reg == TW'(HOLD_CYCLES - 1)) ||
                             (state_reg == RPT_L  && timer_reg == TW'(REPEAT_CYCLES - 1))) begin
                    shift_l_next = 1'b1;
                    state_next   = RPT_L;
                    timer_next   = '0;
                end
            end

            HOLD_R, RPT_R: begin
                if (db == 2'b11) begin
                    state_next = BOTH;
                    timer_next = '0;
                end else if (db != 2'b10) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if ((state_reg == HOLD_R && timer_reg == TW'(HOLD_CYCLES - 1)) ||
                             (state_reg == RPT_R  && timer_reg == TW'(REPEAT_CYCLES - 1))) begin
                    shift_r_next = 1'b1;
                    state_next   = RPT_R;
                    timer_next   = '0;
                end
            end

            BOTH: begin
                if (db != 2'b11) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer_reg == TW'(CLR_CYCLES - 1)) begin
                    home_next  = 1'b1;
                    state_next = LOCK;
                    timer_next = '0;
                end
            end

            LOCK: begin
                // Stay locked until both buttons are released so a leftover press cannot shift.
                timer_next = '0;
                if (db == 2'b00) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        pos_next = pos_reg;
        if (shift_l_next) begin
            pos_next = pos_left(pos_reg);
        end else if (shift_r_next) begin
            pos_next = pos_right(pos_reg);
        end else if (home_next) begin
            pos_next = HOME_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            shift_l_reg <= 1'b0;
            shift_r_reg <= 1'b0;
            home_reg    <= 1'b0;
            pos_reg     <= HOME_POS;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            shift_l_reg <= shift_l_next;
            shift_r_reg <= shift_r_next;
            home_reg    <= home_next;
            pos_reg     <= pos_next;
        end
    end

    assign shift_l = shift_l_reg;
    assign shift_r = shift_r_reg;
    assign home    = home_reg;
    assign pos     = pos_reg;

endmodule
